// File: rtl/alu_ror_seq.sv
// Sequential rotate-right unit: R <= ROR(A, B mod 32), one bit per RUN cycle.
// Define ALU_ROR_MULTISTEP_EN to rotate by 4 bits per cycle while cnt >= 4.
module alu_ror_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] R,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_res;

   logic        w_accept;
   logic        w_big;
   logic [4:0]  w_step;
   logic [31:0] w_rot;
   logic        w_unused_b;

   assign w_unused_b = ^B[31:5];
   assign w_accept   = start && (r_state != S_RUN);

`ifdef ALU_ROR_MULTISTEP_EN
   assign w_big = (r_cnt >= 5'd4);
`else
   assign w_big = 1'b0;
`endif

   assign w_step = w_big ? 5'd4 : 5'd1;
   assign w_rot  = w_big ? {r_res[3:0], r_res[31:4]}
                         : {r_res[0], r_res[31:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 5'd0;
         r_res   <= 32'd0;
      end else begin
         unique case (r_state)
            S_RUN: begin
               if (r_cnt != 5'd0) begin
                  r_res <= w_rot;
                  r_cnt <= r_cnt - w_step;
               end else begin
                  r_state <= S_DONE;
               end
            end
            S_IDLE, S_DONE: begin
               // DONE accepts start directly so ops can run back-to-back
               if (w_accept) begin
                  r_res   <= A;
                  r_cnt   <= B[4:0];
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign R    = r_res;
   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_ror_seq.sv
// Directed bench for alu_ror_seq: vector table plus reset,
// ignored-start and back-to-back sequences.
module tb_alu_ror_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] R;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   alu_ror_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .R     (R),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;

   vec_t vecs[9];

   function automatic int exp_lat(input int m);
`ifdef ALU_ROR_MULTISTEP_EN
      return (m / 4) + (m % 4) + 2;
`else
      return m + 2;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input bit idle_chk);
      int lat;
      int bc;
      int m;
      m = int'(b[4:0]);
      @(negedge clk);
      start = 1'b1;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = ~a;
      B = b + 32'd3;
      lat = 1;
      bc = 0;
      while (!done && lat < 200) begin
         if (busy) bc++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("done_seen", {31'b0, done}, 32'd1);
      chk("result", R, er);
      chk("latency", 32'(lat), 32'(exp_lat(m)));
      chk("busy_cycles", 32'(bc), 32'(exp_lat(m) - 1));
      if (idle_chk) begin
         @(posedge clk);
         #1;
         chk("done_pulse", {31'b0, done}, 32'd0);
         chk("busy_idle", {31'b0, busy}, 32'd0);
         chk("r_hold", R, er);
      end
   endtask

   initial begin
      int dp;
      vecs[0] = '{32'h80000001, 32'd1,  32'hC0000000};
      vecs[1] = '{32'h12345678, 32'd36, 32'h81234567};
      vecs[2] = '{32'hDEADBEEF, 32'd0,  32'hDEADBEEF};
      vecs[3] = '{32'hDEADBEEF, 32'd32, 32'hDEADBEEF};
      vecs[4] = '{32'h00000001, 32'd31, 32'h00000002};
      vecs[5] = '{32'h0000000F, 32'd4,  32'hF0000000};
      vecs[6] = '{32'h00000100, 32'd8,  32'h00000001};
      vecs[7] = '{32'h12345678, 32'd16, 32'h56781234};
      vecs[8] = '{32'h00000001, 32'd7,  32'h02000000};

      rst_n = 1'b0;
      start = 1'b0;
      A = 32'hFFFF_FFFF;
      B = 32'd5;
      #1;
      chk("reset_R", R, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].r, 1'b1);

      // second start during RUN must be ignored
      @(negedge clk);
      start = 1'b1;
      A = 32'h00000001;
      B = 32'd31;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      A = 32'hFFFFFFFF;
      B = 32'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("ign_busy", {31'b0, busy}, 32'd1);
      dp = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done) dp++;
      end
      chk("ign_pulses", 32'(dp), 32'd1);
      chk("ign_result", R, 32'h00000002);

      // async reset in the middle of an operation
      @(negedge clk);
      start = 1'b1;
      A = 32'h0000000F;
      B = 32'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_R", R, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_hold_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'h0000000F, 32'd4, 32'hF0000000, 1'b1);

      // back-to-back: second start issued while in DONE
      run_op(32'h80000001, 32'd1, 32'hC0000000, 1'b0);
      run_op(32'h00000100, 32'd8, 32'h00000001, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_ror_seq.md
ALU_ROR_SEQ -- requirements
Module: alu_ror_seq

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to begin a rotate-right operation.
REQ-004 SHALL have port A, input, 32, operand to be rotated; sampled only at an accepted start.
REQ-005 SHALL have port B, input, 32, rotate amount; only B[4:0] (B mod 32) is used, sampled only at an accepted start.
REQ-006 SHALL have port R, output, 32, working/result register; holds the final value from done until the next accepted start.
REQ-007 SHALL have port busy, output, 1, high while the state is RUN.
REQ-008 SHALL have port done, output, 1, one-cycle pulse; R is the complete result while done is high.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-010 SHALL accept start only in IDLE or DONE; an accepted start loads R<=A and cnt<=B[4:0] (5-bit), and enters RUN.
REQ-011 SHALL ignore start while in RUN, with no change to R, cnt, or the operands.
REQ-012 SHALL, on each RUN edge with cnt!=0, rotate R right by one bit (R<={R[0],R[31:1]}) and decrement cnt by the step size.
REQ-013 SHALL, on the RUN edge where cnt==0, perform no rotation and enter DONE.
REQ-014 SHALL drive busy=1 exactly in RUN and done=1 exactly in DONE; both SHALL be 0 in IDLE.
REQ-015 SHALL leave DONE after exactly one cycle: go to RUN on an accepted start (back-to-back), otherwise go to IDLE.
REQ-016 Latency with single-bit steps SHALL be M+2 edges from the start-sampling edge to the edge that raises done, where M=B[4:0]; M=0 gives 2 edges and R=A.
REQ-017 SHALL produce the result ROR(A, B mod 32); amounts 32 and above wrap, e.g. B=36 gives the same result as B=4.
REQ-018 R SHALL hold its value in IDLE and in DONE; A and B changing after acceptance SHALL NOT affect the result.

Reset
REQ-019 SHALL, while rst_n=0 and independent of clk, force state=IDLE, R=0, cnt=0, busy=0, done=0.
REQ-020 SHALL abort any operation in progress on reset, with no done pulse; after rst_n is released, the next start SHALL begin a fresh operation.
REQ-021 SHALL sample start no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-022 Macro ALU_ROR_MULTISTEP_EN SHALL, when defined, make each RUN edge with cnt>=4 rotate by 4 bits and subtract 4 from cnt. With cnt 1..3, the step SHALL be 1 bit.
REQ-023 With ALU_ROR_MULTISTEP_EN defined, latency SHALL be (M div 4)+(M mod 4)+2 edges; the result SHALL be identical to single-step mode.
REQ-024 Without ALU_ROR_MULTISTEP_EN, the block SHALL use single-bit steps only, per REQ-012 and REQ-016.

Verification
REQ-025 A=0x80000001, B=1, start pulse -> done after 3 edges, R=0xC0000000, busy high for 2 cycles.
REQ-026 A=0x12345678, B=36 -> R=0x81234567; done after 6 edges (single-step) or 3 edges (ALU_ROR_MULTISTEP_EN).
REQ-027 A=0xDEADBEEF, B=0 -> done after 2 edges, R=0xDEADBEEF; B=32 gives the identical response.
REQ-028 A=0x00000001, B=31, start re-asserted with A=0xFFFFFFFF on the second RUN cycle -> second start ignored; final R=0x00000002, single done pulse.
REQ-029 A=0x0000000F, B=8, rst_n pulled low on the 4th RUN cycle (asynchronously, between edges) -> R=0 and busy=0 immediately, no done; after release, start with B=4 -> R=0xF0000000.
REQ-030 Back-to-back: start held high in DONE with A=0x00000100, B=8 -> RUN entered directly, with no IDLE cycle; next result R=0x00000001.
